alu_cmd_sequencer: RTL and testbench

- Upstream driver stage for the TinyALU datapath.
- Accepts ALU commands {A, B, op} over a valid/ready stream and buffers them in a small FIFO.
- Issues each command to the ALU using its start/done protocol, captures the result, and returns it on a valid/ready response stream.
- Handles no-op commands locally and aborts hung operations with a timeout.

---
 rtl/alu_cmd_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and start/done sequencer in front of the TinyALU
// Optional feature: define ALU_SEQ_TAG_EN to carry a 4-bit tag from cmd_tag to rsp_tag.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
`ifdef ALU_SEQ_TAG_EN
  input  logic [3:0]  cmd_tag,
  output logic [3:0]  rsp_tag,
`endif
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
`ifdef ALU_SEQ_TAG_EN
  localparam int EW = 23;
`else
  localparam int EW = 19;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   head;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  // A command leaves the FIFO only when the FSM can issue it on this edge.
  assign pop       = !empty && ((state == S_IDLE) || (state == S_RESP && rsp_ready));
  assign busy      = (state != S_IDLE) || !empty;
  assign head      = mem[rd_ptr];

`ifdef ALU_SEQ_TAG_EN
  logic [3:0] cur_tag;
  assign wr_entry = {cmd_tag, cmd_op, cmd_b, cmd_a};
`else
  assign wr_entry = {cmd_op, cmd_b, cmd_a};
`endif

  // FIFO storage: write-only array, no reset needed since count guards reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sequencer FSM: issue from FIFO, wait for done or timeout, hold response until taken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
`ifdef ALU_SEQ_TAG_EN
      cur_tag    <= '0;
      rsp_tag    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: ;
        S_BUSY: begin
          timer <= timer + 1'b1;
          if (alu_done) begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
`ifdef ALU_SEQ_TAG_EN
            rsp_tag    <= cur_tag;
`endif
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
`ifdef ALU_SEQ_TAG_EN
            rsp_tag    <= cur_tag;
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Issue overrides the state defaults above; shared by IDLE and RESP-handshake.
      if (pop) begin
        alu_a  <= head[7:0];
        alu_b  <= head[15:8];
        alu_op <= head[18:16];
`ifdef ALU_SEQ_TAG_EN
        cur_tag <= head[22:19];
`endif
        if (head[18:16] != 3'b000) begin
          alu_start <= 1'b1;
          timer     <= '0;
          state     <= S_BUSY;
        end else begin
          rsp_result <= '0;
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
`ifdef ALU_SEQ_TAG_EN
          rsp_tag    <= head[22:19];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard testbench for alu_cmd_sequencer with a TinyALU model
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic        busy;

  alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   hs_log[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rsp_cnt = 0;
  int   start_cnt = 0;
  bit   stuck = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // TinyALU-like model: single-cycle ops raise done 1 cycle after start, mult after 4.
  int acnt = 0;
  always @(posedge clk) begin
    if (!reset_n || !alu_start || stuck) begin
      acnt     <= 0;
      alu_done <= 1'b0;
    end else begin
      acnt     <= acnt + 1;
      alu_done <= ((acnt + 1) == (alu_op[2] ? 4 : 1));
      case (alu_op)
        3'b001:  alu_result <= 16'(alu_a) + 16'(alu_b);
        3'b010:  alu_result <= {8'h00, alu_a & alu_b};
        3'b011:  alu_result <= {8'h00, alu_a ^ alu_b};
        default: alu_result <= 16'(alu_a) * 16'(alu_b);
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops the scoreboard and compares.
  always @(negedge clk) begin
    if (reset_n && alu_start) start_cnt++;
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_result", int'(rsp_result), int'(e.res));
        chk("rsp_err", int'(rsp_err), int'(e.err));
      end
      hs_log.push_back(cyc);
      rsp_cnt++;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [15:0] er, input logic ee, input bit track,
                      output int acc);
    bit ok = 1'b0;
    int waited = 0;
    acc = -1;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    while (!ok && waited < 60) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok  = 1'b1;
        acc = cyc;
        if (track) exp_q.push_back('{res: er, err: ee});
      end
      @(posedge clk); #1;
      waited++;
    end
    cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (rsp_cnt < target) chk("rsp_wait_timeout", rsp_cnt, target);
  endtask

  initial begin
    int n0, s0, acc, d;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_alu_start", int'(alu_start), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clk); #1;

    // add latency N+4
    n0 = rsp_cnt; s0 = start_cnt;
    send(8'h12, 8'h34, 3'b001, 16'h0046, 1'b0, 1'b1, acc);
    wait_rsp(n0 + 1);
    chk("add_latency", hs_log[$] - acc, 4);
    chk("add_start_cycles", start_cnt - s0, 2);

    // mult latency N+7, start high 5 cycles
    n0 = rsp_cnt; s0 = start_cnt;
    send(8'hFF, 8'hFF, 3'b100, 16'hFE01, 1'b0, 1'b1, acc);
    wait_rsp(n0 + 1);
    chk("mult_latency", hs_log[$] - acc, 7);
    chk("mult_start_cycles", start_cnt - s0, 5);

    // fill FIFO while response is stalled, then drain in order
    repeat (2) @(posedge clk); #1;
    n0 = rsp_cnt;
    rsp_ready = 1'b0;
    send(8'h01, 8'h01, 3'b001, 16'h0002, 1'b0, 1'b1, acc);
    send(8'hF0, 8'h3C, 3'b010, 16'h0030, 1'b0, 1'b1, acc);
    send(8'hFF, 8'h0F, 3'b011, 16'h00F0, 1'b0, 1'b1, acc);
    send(8'h03, 8'h05, 3'b111, 16'h000F, 1'b0, 1'b1, acc);
    send(8'h09, 8'h09, 3'b000, 16'h0000, 1'b0, 1'b1, acc);
    @(negedge clk);
    chk("full_cmd_ready", int'(cmd_ready), 0);
    chk("full_busy", int'(busy), 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_cmd_ready_same_cycle", int'(cmd_ready), 0);
    wait_rsp(n0 + 5);

    // stuck done -> timeout after 16 start cycles, then normal op
    repeat (2) @(posedge clk); #1;
    stuck = 1'b1;
    n0 = rsp_cnt; s0 = start_cnt;
    send(8'h01, 8'h02, 3'b001, 16'h0000, 1'b1, 1'b1, acc);
    wait_rsp(n0 + 1);
    chk("timeout_latency", hs_log[$] - acc, 18);
    chk("timeout_start_cycles", start_cnt - s0, 16);
    stuck = 1'b0;
    send(8'h03, 8'h04, 3'b001, 16'h0007, 1'b0, 1'b1, acc);
    wait_rsp(n0 + 2);

    // nop completes locally in N+2 without a start
    repeat (2) @(posedge clk); #1;
    n0 = rsp_cnt; s0 = start_cnt;
    send(8'h05, 8'h07, 3'b000, 16'h0000, 1'b0, 1'b1, acc);
    wait_rsp(n0 + 1);
    chk("nop_latency", hs_log[$] - acc, 2);
    chk("nop_start_cycles", start_cnt - s0, 0);

    // back-to-back adds: one response every 3 cycles
    repeat (2) @(posedge clk); #1;
    n0 = rsp_cnt;
    send(8'h10, 8'h20, 3'b001, 16'h0030, 1'b0, 1'b1, acc);
    send(8'h80, 8'h80, 3'b001, 16'h0100, 1'b0, 1'b1, acc);
    send(8'hAA, 8'h55, 3'b011, 16'h00FF, 1'b0, 1'b1, acc);
    wait_rsp(n0 + 3);
    d = hs_log[$] - hs_log[hs_log.size() - 2];
    chk("b2b_spacing", d, 3);

    // reset during a BUSY mult: outputs cleared, no response
    repeat (2) @(posedge clk); #1;
    n0 = rsp_cnt;
    send(8'h11, 8'h22, 3'b100, 16'h0000, 1'b0, 1'b0, acc);
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    chk("pre_reset_alu_start", int'(alu_start), 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_alu_start", int'(alu_start), 0);
    chk("rst_alu_ops", int'({alu_a, alu_b, alu_op}), 0);
    chk("rst_rsp", int'({rsp_valid, rsp_err, rsp_result}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    repeat (12) @(posedge clk); #1;
    chk("rst_no_response", rsp_cnt - n0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
